// File: rtl/l1_cache_pkg.sv
// Shared types and constants for the L1 cache: line type, FSM states, line geometry.
package lc3b_types;
  localparam int OFFSET_W   = 4;
  localparam int LINE_WORDS = 8;

  typedef logic [127:0] lc3b_c_line;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } lc3b_c_state;
endpackage

// File: rtl/l1_cache_if.sv
// CPU-side request/response port plus next-level line port of one L1 cache.
// slave is the cache view; master is the CPU plus lower-memory view.
interface l1_cache_if;
  logic         mem_read;
  logic         mem_write;
  logic [1:0]   mem_wmask;
  logic [15:0]  mem_address;
  logic [15:0]  mem_wdata;
  logic         mem_resp;
  logic [15:0]  mem_rdata;
  logic         mem_miss;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  modport slave (
    input  mem_read, mem_write, mem_wmask, mem_address, mem_wdata,
    output mem_resp, mem_rdata, mem_miss,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output mem_read, mem_write, mem_wmask, mem_address, mem_wdata,
    input  mem_resp, mem_rdata, mem_miss,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/l1_cache_control.sv
// Miss-handling FSM: hit response, miss pulse, writeback/fill strobes,
// request-latch enable and line-install strobe.
module l1_cache_control
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        hit,
  input  logic        victim_dirty,
  input  logic        pmem_resp,
  output lc3b_c_state state,
  output logic        mem_resp,
  output logic        mem_miss,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic        latch_en,
  output logic        install
);

  lc3b_c_state next;

  // State register; reset abandons any miss in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end

  // Next state and strobes; everything is held low while reset is asserted
  // so a request present during reset produces neither resp nor miss.
  always_comb begin
    next       = state;
    mem_resp   = 1'b0;
    mem_miss   = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    latch_en   = 1'b0;
    install    = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (req) begin
            if (hit) begin
              mem_resp = 1'b1;
            end else begin
              mem_miss = 1'b1;
              latch_en = 1'b1;
              next     = victim_dirty ? WRITEBACK : ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          pmem_write = 1'b1;
          if (pmem_resp) next = ALLOCATE;
        end
        ALLOCATE: begin
          pmem_read = 1'b1;
          if (pmem_resp) begin
            install = 1'b1;
            next    = IDLE;
          end
        end
        default: next = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/l1_cache.sv
// Direct-mapped, write-back, write-allocate L1 cache with 16-byte lines.
// Hits respond combinationally; misses write back a dirty victim, then fill.
module l1_cache
  import lc3b_types::*;
#(
  parameter int NUM_SETS = 8
) (
  input logic       clk,
  input logic       rst_n,
  l1_cache_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 16 - IDX_W - OFFSET_W;

  logic [NUM_SETS-1:0] valid;
  logic [NUM_SETS-1:0] dirty;
  logic [TAG_W-1:0]    tags [NUM_SETS];
  lc3b_c_line          data [NUM_SETS];

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [2:0]       word;
  logic [TAG_W-1:0] lat_tag;
  logic [IDX_W-1:0] lat_idx;
  logic             req, hit, victim_dirty, latch_en, install, wr_hit;
  lc3b_c_state      state;
  lc3b_c_line       line;

  assign req_tag      = bus.mem_address[15 -: TAG_W];
  assign req_idx      = bus.mem_address[OFFSET_W +: IDX_W];
  assign word         = bus.mem_address[3:1];
  assign req          = bus.mem_read | bus.mem_write;
  assign hit          = valid[req_idx] && (tags[req_idx] == req_tag);
  assign victim_dirty = valid[req_idx] && dirty[req_idx];
  assign line         = data[req_idx];
  // Write wins over a simultaneous read.
  assign wr_hit       = bus.mem_resp && bus.mem_write;

  l1_cache_control u_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .hit          (hit),
    .victim_dirty (victim_dirty),
    .pmem_resp    (bus.pmem_resp),
    .state        (state),
    .mem_resp     (bus.mem_resp),
    .mem_miss     (bus.mem_miss),
    .pmem_read    (bus.pmem_read),
    .pmem_write   (bus.pmem_write),
    .latch_en     (latch_en),
    .install      (install)
  );

  // Capture the missing address so the CPU may change or drop it mid-miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_tag <= '0;
      lat_idx <= '0;
    end else if (latch_en) begin
      lat_tag <= req_tag;
      lat_idx <= req_idx;
    end
  end

  // Valid/dirty bookkeeping: fill installs clean, byte-enabled write hit dirties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      dirty <= '0;
    end else if (install) begin
      valid[lat_idx] <= 1'b1;
      dirty[lat_idx] <= 1'b0;
    end else if (wr_hit && (|bus.mem_wmask)) begin
      dirty[req_idx] <= 1'b1;
    end
  end

  // Tag/data arrays: line install on fill, per-byte update on write hit.
  always_ff @(posedge clk) begin
    if (install) begin
      data[lat_idx] <= bus.pmem_rdata;
      tags[lat_idx] <= lat_tag;
    end else if (wr_hit) begin
      if (bus.mem_wmask[0]) data[req_idx][{word, 4'b0000} +: 8] <= bus.mem_wdata[7:0];
      if (bus.mem_wmask[1]) data[req_idx][{word, 4'b1000} +: 8] <= bus.mem_wdata[15:8];
    end
  end

  // Read word is only driven while a response is being given.
  always_comb begin
    bus.mem_rdata = '0;
    if (bus.mem_resp) bus.mem_rdata = line[{word, 4'b0000} +: 16];
  end

  // Line address/data toward the next level: victim on writeback, latched request on fill.
  always_comb begin
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;
    case (state)
      WRITEBACK: begin
        bus.pmem_address = {tags[lat_idx], lat_idx, 4'b0000};
        bus.pmem_wdata   = data[lat_idx];
      end
      ALLOCATE: bus.pmem_address = {lat_tag, lat_idx, 4'b0000};
      default: ;
    endcase
  end

endmodule

// File: doc/l1_cache.md
Name: l1_cache

Overview:
- Direct-mapped, write-back, write-allocate L1 cache.
- Acts as the responder on one CPU memory port: the instruction port (a) or the data port (b). One instance sits behind each port.
- Takes word/byte requests with a read/write strobe and returns mem_resp plus read data.
- On a miss, evicts dirty lines and fills 128-bit lines from the next level (L2 or physical memory).

Parameters:
- NUM_SETS, 8, number of lines; power of two, >=2. IDX_W = log2(NUM_SETS).
- Fixed geometry: 16-byte line (8 words), OFFSET_W = 4, TAG_W = 16 - IDX_W - 4.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- mem_read  in  1  CPU read request; held until mem_resp.
- mem_write  in  1  CPU write request; held until mem_resp.
- mem_wmask  in  2  byte enables; bit1 = high byte, bit0 = low byte.
- mem_address  in  16  byte address; bit0 is ignored for word select.
- mem_wdata  in  16  write data.
- mem_resp  out  1  request complete this cycle.
- mem_rdata  out  16  read word, valid when mem_resp && mem_read.
- mem_miss  out  1  one-cycle pulse per miss; feeds the miss performance counters.
- pmem_read  out  1  line fill request.
- pmem_write  out  1  line writeback request.
- pmem_address  out  16  line address; low 4 bits are 0.
- pmem_wdata  out  128  evicted line.
- pmem_rdata  in  128  fill line.
- pmem_resp  in  1  lower level done; single-cycle pulse.

Behaviour:
- Address split: tag = addr[15:4+IDX_W], index = addr[4+IDX_W-1:4], word = addr[3:1].
- Per set state: valid, dirty, tag, 128-bit data.
- Async reset clears all valid and dirty bits and forces state IDLE. Data and tag arrays are not reset.
- Output values during and after reset: mem_resp=0, mem_miss=0, pmem_read=0, pmem_write=0, pmem_address=0.
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE, no request: all outputs 0.
- IDLE, request and hit (valid && tag match):
  - mem_resp=1 combinationally in the same cycle (0-cycle hit latency).
  - mem_rdata = data[index][word*16 +: 16].
  - Write: at the clock edge, update enabled bytes only and set dirty. wmask=00 still responds but modifies nothing.
- IDLE, request and miss:
  - mem_resp=0, mem_miss=1 for exactly this cycle.
  - Next state is WRITEBACK if valid && dirty, otherwise ALLOCATE.
- WRITEBACK:
  - pmem_write=1, pmem_address={stored tag, index, 4'b0}, pmem_wdata=line.
  - Hold until pmem_resp, then go to ALLOCATE.
- ALLOCATE:
  - pmem_read=1, pmem_address={req tag, index, 4'b0}.
  - On pmem_resp: write the line, set tag, valid=1, dirty=0, go to IDLE. The request then hits on the next cycle.
- pmem_read and pmem_write are never asserted together. mem_miss is not re-asserted for the re-check hit.
- mem_read && mem_write together is illegal; write takes precedence.
- CPU drops its request mid-miss: the fill still completes and the line is installed; no response is issued.
- CPU changes address mid-miss: the index and tag are latched at miss detection, and the latched values drive pmem_address until return to IDLE.
- Async reset mid-miss: the FSM returns to IDLE, pmem strobes drop immediately, and a late pmem_resp is ignored in IDLE.
- A write hit to a line makes the following read of the same word return the new data with 0 latency. Forwarding through the array is sufficient because writes commit at the edge.

Decomposition:
- Add to package lc3b_types:
  - lc3b_c_line (logic [127:0])
  - lc3b_c_state enum {IDLE, WRITEBACK, ALLOCATE}
  - constants OFFSET_W=4 and LINE_WORDS=8
- Sub-module l1_cache_control: FSM plus strobe, mem_miss, and latch-enable generation.
- l1_cache top level: arrays, tag compare, word/byte muxing, pmem address muxing.

Test Plan:
- Reset, then read 0x0040 with NUM_SETS=8 -> mem_miss pulses once, no WRITEBACK, pmem_read with pmem_address=0x0040. Return line with word0=0x1234 -> mem_resp next cycle, mem_rdata=0x1234.
- Read 0x0046 after that fill -> mem_resp same cycle as request, mem_rdata = word3 of the line, no pmem activity.
- Write 0x0040 with wmask=01 and wdata=0xABCD -> same-cycle resp. A following read of 0x0040 returns 0x12CD and sets dirty.
- Read 0x00C0 (same index 4, new tag) -> pmem_write first at 0x0040 with the dirty line (word0=0x12CD), then pmem_read at 0x00C0, then mem_resp.
- Assert rst_n=0 while in ALLOCATE -> pmem_read drops asynchronously. After release, a read of 0x00C0 misses again.
- Miss at 0x0100, then drop mem_read during ALLOCATE -> the line is installed with no mem_resp. Re-requesting 0x0100 hits with no mem_miss.
